// File: rtl/textlcd_pkg.sv
// Shared definitions for the text-LCD bus: opcode masks/values, DDRAM geometry
// and the responder state encoding.
package textlcd_pkg;

   localparam int DDRAM_DEPTH = 32;
   localparam int ADDR_W      = 5;

   localparam logic [7:0] CHAR_BLANK = 8'h20;
   localparam logic [6:0] LINE2_BASE = 7'h40;

   localparam logic [7:0] OP_NONE     = 8'h00;
   localparam logic [7:0] OP_CLEAR    = 8'h01;
   localparam logic [7:0] OPM_HOME    = 8'hFE;
   localparam logic [7:0] OPV_HOME    = 8'h02;
   localparam logic [7:0] OPM_ENTRY   = 8'hFC;
   localparam logic [7:0] OPV_ENTRY   = 8'h04;
   localparam logic [7:0] OPM_DISP    = 8'hF8;
   localparam logic [7:0] OPV_DISP    = 8'h08;
   localparam logic [7:0] OPM_SHIFT   = 8'hF0;
   localparam logic [7:0] OPV_SHIFT   = 8'h10;
   localparam logic [7:0] OPM_FUNC    = 8'hE0;
   localparam logic [7:0] OPV_FUNC    = 8'h20;
   localparam logic [7:0] FUNC_REQ    = 8'h18;
   localparam logic [7:0] OPM_CGRAM   = 8'hC0;
   localparam logic [7:0] OPV_CGRAM   = 8'h40;
   localparam logic [7:0] OPM_DDRAM   = 8'h80;
   localparam logic [7:0] OPV_DDRAM   = 8'h80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      HOLD  = 2'd2
   } lcd_state_e;

   function automatic logic op_match(input logic [7:0] d, input logic [7:0] mask,
                                     input logic [7:0] val);
      return (d & mask) == val;
   endfunction

endpackage

// File: rtl/textlcd_rx_lcd_bus_sync.sv
// Two-stage synchronizer for the LCD bus with E falling-edge detection; the
// captured bus comes from the second stage, which still holds the E-high values.
module lcd_bus_sync (
   input  logic       clk,
   input  logic       resetn,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       fall,
   output logic       cap_rs,
   output logic       cap_rw,
   output logic [7:0] cap_data
);

   logic       e_q1, e_q2, rs_q1, rs_q2, rw_q1, rw_q2;
   logic [7:0] data_q1, data_q2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         e_q1    <= 1'b0;
         e_q2    <= 1'b0;
         rs_q1   <= 1'b0;
         rs_q2   <= 1'b0;
         rw_q1   <= 1'b0;
         rw_q2   <= 1'b0;
         data_q1 <= 8'h00;
         data_q2 <= 8'h00;
      end else begin
         e_q1    <= lcd_e;
         e_q2    <= e_q1;
         rs_q1   <= lcd_rs;
         rs_q2   <= rs_q1;
         rw_q1   <= lcd_rw;
         rw_q2   <= rw_q1;
         data_q1 <= lcd_data;
         data_q2 <= data_q1;
      end
   end

   assign fall     = e_q2 & ~e_q1;
   assign cap_rs   = rs_q2;
   assign cap_rw   = rw_q2;
   assign cap_data = data_q2;

endmodule

// File: rtl/textlcd_rx.sv
// Receive-side LCD bus model: decodes instructions/data from the bus and keeps
// a 2x16 DDRAM mirror with a registered read port.
module textlcd_rx
   import textlcd_pkg::*;
#(
   parameter int CMD_BUSY = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [4:0] cursor,
   output logic       disp_on,
   output logic       busy,
   output logic       wr_strobe,
   output logic       cmd_err,
   output logic [1:0] dbg_state
);

   localparam int CNT_W = (CMD_BUSY < 2) ? 1 : $clog2(CMD_BUSY + 1);

   logic       fall, cap_rs, cap_rw;
   logic [7:0] cap_data;

   lcd_bus_sync u_sync (
      .clk      (clk),
      .resetn   (resetn),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data),
      .fall     (fall),
      .cap_rs   (cap_rs),
      .cap_rw   (cap_rw),
      .cap_data (cap_data)
   );

   lcd_state_e       state_q, state_d;
   logic [4:0]       fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       cursor_d;
   logic             id_q, id_d;
   logic             disp_d, ws_d, err_d;
   logic             cmd_ok;
   logic             we;
   logic [4:0]       waddr;
   logic [7:0]       wdata;
   logic [6:0]       dd_a;
   logic [7:0]       mem [DDRAM_DEPTH];

   assign dd_a = cap_data[6:0];

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      cursor_d = cursor;
      id_d     = id_q;
      disp_d   = disp_on;
      ws_d     = 1'b0;
      err_d    = 1'b0;
      cmd_ok   = 1'b0;
      we       = 1'b0;
      waddr    = fill_q;
      wdata    = CHAR_BLANK;

      case (state_q)
         CLEAR: begin
            we     = 1'b1;
            fill_d = fill_q + 5'd1;
            if (fill_q == 5'd31) state_d = IDLE;
         end
         HOLD: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: ;
      endcase

      // Reads are ignored entirely; anything else arriving while busy is dropped.
      if (fall && !cap_rw) begin
         if (state_q != IDLE) begin
            err_d = 1'b1;
         end else if (cap_rs) begin
            we       = 1'b1;
            waddr    = cursor;
            wdata    = cap_data;
            ws_d     = 1'b1;
            cursor_d = id_q ? cursor + 5'd1 : cursor - 5'd1;
         end else if (cap_data == OP_NONE) begin
            err_d = 1'b1;
         end else if (cap_data == OP_CLEAR) begin
            state_d  = CLEAR;
            fill_d   = 5'd0;
            cursor_d = 5'd0;
            id_d     = 1'b1;
         end else if (op_match(cap_data, OPM_HOME, OPV_HOME)) begin
            cursor_d = 5'd0;
            cmd_ok   = 1'b1;
         end else if (op_match(cap_data, OPM_ENTRY, OPV_ENTRY)) begin
            id_d   = cap_data[1];
            cmd_ok = 1'b1;
         end else if (op_match(cap_data, OPM_DISP, OPV_DISP)) begin
            disp_d = cap_data[2];
            cmd_ok = 1'b1;
         end else if (op_match(cap_data, OPM_SHIFT, OPV_SHIFT)) begin
            cmd_ok = 1'b1;
         end else if (op_match(cap_data, OPM_FUNC, OPV_FUNC)) begin
            if ((cap_data & FUNC_REQ) == FUNC_REQ) cmd_ok = 1'b1;
            else                                   err_d  = 1'b1;
         end else if (op_match(cap_data, OPM_CGRAM, OPV_CGRAM)) begin
            cmd_ok = 1'b1;
         end else begin
            if (dd_a[6:4] == 3'b000) begin
               cursor_d = {1'b0, dd_a[3:0]};
               cmd_ok   = 1'b1;
            end else if ((dd_a & 7'h70) == LINE2_BASE) begin
               cursor_d = {1'b1, dd_a[3:0]};
               cmd_ok   = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end

         if (cmd_ok && (CMD_BUSY != 0)) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(CMD_BUSY - 1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= CLEAR;
         fill_q    <= 5'd0;
         cnt_q     <= '0;
         cursor    <= 5'd0;
         id_q      <= 1'b1;
         disp_on   <= 1'b0;
         wr_strobe <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         cnt_q     <= cnt_d;
         cursor    <= cursor_d;
         id_q      <= id_d;
         disp_on   <= disp_d;
         wr_strobe <= ws_d;
         cmd_err   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rd_char <= 8'h00;
      else         rd_char <= mem[rd_addr];
   end

   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_textlcd_rx.sv
// Self-checking bench for textlcd_rx: directed scenarios plus randomized bus
// traffic against a transaction-level model of the display.
module tb_textlcd_rx;

   localparam int CMD_BUSY = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
   logic [7:0] lcd_data = 8'h00;
   logic [4:0] rd_addr = 5'd0;
   logic [7:0] rd_char;
   logic [4:0] cursor;
   logic       disp_on, busy, wr_strobe, cmd_err;
   logic [1:0] dbg_state;

   textlcd_rx #(.CMD_BUSY(CMD_BUSY)) dut (
      .clk(clk), .resetn(resetn), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .cursor(cursor),
      .disp_on(disp_on), .busy(busy), .wr_strobe(wr_strobe), .cmd_err(cmd_err),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_mem [32];
   int         m_cur, m_id, m_disp, exp_ws, exp_err;
   int         ws_seen, err_seen;
   int         n_tests, n_fail;
   logic [7:0] exp_q [$];

   always @(negedge clk) begin
      if (resetn) begin
         if (wr_strobe) ws_seen++;
         if (cmd_err)   err_seen++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Applies one bus transaction to the model; returns expected busy length.
   function automatic int model_xact(input bit rs, input bit rw, input logic [7:0] d,
                                     input bit busy_now);
      int a;
      if (rw) return 0;
      if (busy_now) begin exp_err++; return 0; end
      if (rs) begin
         m_mem[m_cur] = d;
         exp_ws++;
         m_cur = (m_id != 0) ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
         return 0;
      end
      if (d == 0) begin exp_err++; return 0; end
      if (d == 1) begin
         for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
         m_cur = 0; m_id = 1;
         return 32;
      end
      if (d < 4)        m_cur = 0;
      else if (d < 8)   m_id = int'(d[1]);
      else if (d < 16)  m_disp = int'(d[2]);
      else if (d < 32)  ;
      else if (d < 64) begin
         if (!(d[4] && d[3])) begin exp_err++; return 0; end
      end
      else if (d < 128) ;
      else begin
         a = int'(d) - 128;
         if (a < 16) m_cur = a;
         else if (a >= 64 && a < 80) m_cur = 16 + a - 64;
         else begin exp_err++; return 0; end
      end
      return CMD_BUSY;
   endfunction

   task automatic lcd_xact(input bit rs, input bit rw, input logic [7:0] d,
                           input bit busy_now, input bit measure);
      int bl, exp_bl;
      @(negedge clk);
      lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
      repeat (6) @(negedge clk);
      lcd_e = 1'b0;
      exp_bl = model_xact(rs, rw, d, busy_now);
      if (measure) begin
         bl = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bl++;
            else if (bl > 0) break;
         end
         check("busy_len", bl, exp_bl);
      end else begin
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 100) begin @(negedge clk); t++; end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic scan_ddram();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rd_addr = 5'(i);
         exp_q.push_back(m_mem[i]);
         @(negedge clk);
         check($sformatf("ddram[%0d]", i), rd_char, exp_q.pop_front());
      end
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_cursor"}, cursor, m_cur);
      check({tag, "_disp_on"}, disp_on, m_disp);
      check({tag, "_wr_strobes"}, ws_seen, exp_ws);
      check({tag, "_cmd_errs"}, err_seen, exp_err);
   endtask

   initial begin
      logic [7:0] hello [5];
      logic [7:0] d;
      bit rs, rw;
      n_tests = 0; n_fail = 0; ws_seen = 0; err_seen = 0;
      exp_ws = 0; exp_err = 0; m_cur = 0; m_id = 1; m_disp = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

      // reset state and post-reset clear timing
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1);
      check("rst_cursor", cursor, 0);
      check("rst_disp_on", disp_on, 0);
      check("rst_rd_char", rd_char, 8'h00);
      check("rst_wr_strobe", wr_strobe, 0);
      check("rst_cmd_err", cmd_err, 0);
      resetn = 1'b1;
      repeat (31) @(negedge clk);
      check("clear_busy_31", busy, 1);
      @(negedge clk);
      check("clear_busy_32", busy, 0);
      scan_ddram();
      check_regs("reset");

      // init sequence and HELLO
      lcd_xact(0, 0, 8'h38, 0, 1);
      lcd_xact(0, 0, 8'h0C, 0, 1);
      lcd_xact(0, 0, 8'h06, 0, 1);
      lcd_xact(0, 0, 8'h80, 0, 1);
      for (int i = 0; i < 5; i++) lcd_xact(1, 0, hello[i], 0, 1);
      check_regs("hello");
      scan_ddram();

      // line 2 fill with wrap back to 0
      lcd_xact(0, 0, 8'hC0, 0, 1);
      for (int i = 0; i < 16; i++) lcd_xact(1, 0, 8'(8'h30 + i), 0, 1);
      check_regs("line2");
      scan_ddram();

      // decrement mode wraps 0 -> 31
      lcd_xact(0, 0, 8'h04, 0, 1);
      lcd_xact(0, 0, 8'h80, 0, 1);
      lcd_xact(1, 0, 8'h41, 0, 1);
      check_regs("decr");
      scan_ddram();

      // write during clear is dropped
      lcd_xact(0, 0, 8'h01, 0, 0);
      lcd_xact(1, 0, 8'h5A, 1, 0);
      wait_idle();
      check_regs("drop");
      scan_ddram();

      // illegal instructions, then idle read pattern
      lcd_xact(1, 0, 8'h61, 0, 1);
      lcd_xact(0, 0, 8'h90, 0, 1);
      lcd_xact(0, 0, 8'h28, 0, 1);
      check_regs("illegal");
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_data = 8'($urandom_range(0, 255)); lcd_e = 1'b1;
         repeat (4) @(negedge clk);
         lcd_e = 1'b0;
         repeat (3) @(negedge clk);
      end
      lcd_data = 8'h00;
      repeat (4) @(negedge clk);
      check("rw_busy", busy, 0);
      check_regs("rw_idle");

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         rs = 1'($urandom_range(0, 1));
         rw = ($urandom_range(0, 7) == 0);
         if (rs) d = 8'($urandom_range(0, 255));
         else begin
            case ($urandom_range(0, 9))
               0: d = 8'h01;
               1: d = 8'($urandom_range(2, 3));
               2: d = 8'($urandom_range(4, 7));
               3: d = 8'($urandom_range(8, 15));
               4: d = 8'($urandom_range(16, 31));
               5: d = 8'($urandom_range(32, 63));
               6: d = 8'($urandom_range(64, 127));
               7: d = 8'($urandom_range(128, 143));
               8: d = 8'($urandom_range(192, 207));
               default: d = 8'($urandom_range(0, 255));
            endcase
         end
         lcd_xact(rs, rw, d, 0, 1);
      end
      check_regs("random");
      scan_ddram();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
